// File: rtl/writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : writeback_stage_pkg
// Purpose : Shared Y86-64 encodings and bus widths for the writeback stage
//           and its register file: status codes, the "no register" index,
//           and a helper that classifies terminating status codes.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package writeback_stage_pkg;

    // Bus widths
    localparam int c_STAT_W  = 3;
    localparam int c_ADDR_W  = 64;
    localparam int c_ICODE_W = 4;
    localparam int c_DATA_W  = 64;
    localparam int c_REG_W   = 4;

    // Status encodings; c_STAT_ZERO marks a pipeline bubble
    localparam logic [c_STAT_W-1:0] c_STAT_ZERO = 3'd0;
    localparam logic [c_STAT_W-1:0] c_SAOK      = 3'd1;
    localparam logic [c_STAT_W-1:0] c_SHLT      = 3'd2;
    localparam logic [c_STAT_W-1:0] c_SADR      = 3'd3;
    localparam logic [c_STAT_W-1:0] c_SINS      = 3'd4;

    // Register index meaning "no register"
    localparam logic [c_REG_W-1:0]  c_NREG      = 4'hF;

    // True for the status codes that stop the machine
    function automatic logic is_terminal(input logic [c_STAT_W-1:0] stat);
        return (stat == c_SHLT) || (stat == c_SADR) || (stat == c_SINS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/writeback_stage_regfile.sv
`default_nettype none
// ============================================================================
// Module  : writeback_stage_regfile
// Purpose : Y86-64 architectural register file. NUM_REGS x DATA_W entries,
//           two write ports (E and M, M has priority on the same index),
//           two purely combinational read ports, synchronous reset.
//           Index c_NREG is never stored: writes to it are dropped and reads
//           of it return zero.
// Ports   : clk, rst            clock / synchronous active-high reset
//           i_we                global write enable (instruction commits)
//           i_dstE, i_valE      E write port
//           i_dstM, i_valM      M write port
//           i_srcA, i_srcB      read addresses
//           o_rvalA, o_rvalB    read data
// Rev     : 1.0  initial release
// ============================================================================
module writeback_stage_regfile
    import writeback_stage_pkg::*;
#(
    parameter int NUM_REGS = 15,
    parameter int DATA_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_we,
    input  logic [c_REG_W-1:0] i_dstE,
    input  logic [DATA_W-1:0]  i_valE,
    input  logic [c_REG_W-1:0] i_dstM,
    input  logic [DATA_W-1:0]  i_valM,
    input  logic [c_REG_W-1:0] i_srcA,
    input  logic [c_REG_W-1:0] i_srcB,
    output logic [DATA_W-1:0]  o_rvalA,
    output logic [DATA_W-1:0]  o_rvalB
);

    logic [DATA_W-1:0] r_regs [0:NUM_REGS-1];
    logic [DATA_W-1:0] w_rvalA;
    logic [DATA_W-1:0] w_rvalB;

    // M is checked first so that popq %rsp leaves the popped value behind.
    // The loop index never reaches c_NREG, so those writes fall away.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rst) begin
                r_regs[i] <= '0;
            end else if (i_we && (i_dstM == c_REG_W'(i))) begin
                r_regs[i] <= i_valM;
            end else if (i_we && (i_dstE == c_REG_W'(i))) begin
                r_regs[i] <= i_valE;
            end
        end
    end

    // No write->read bypass: decode forwards from W itself.
    always_comb begin
        w_rvalA = '0;
        w_rvalB = '0;
        if (i_srcA < c_REG_W'(NUM_REGS)) w_rvalA = r_regs[i_srcA];
        if (i_srcB < c_REG_W'(NUM_REGS)) w_rvalB = r_regs[i_srcB];
    end

    assign o_rvalA = w_rvalA;
    assign o_rvalB = w_rvalB;

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module  : writeback_stage
// Purpose : Consumer end of the W pipeline register. Commits W_valE/W_valM
//           into the register file, serves decode's read ports, and owns
//           architectural status: sticky halt, W stall, retire trace and
//           the instret / cycle counters.
// Ports   : clk_i, rst_i                 clock / sync active-high reset
//           W_stat_i .. W_dstM_i         instruction currently in W
//           d_srcA_i, d_srcB_i           decode read addresses
//           d_rvalA_o, d_rvalB_o         decode read data (0 for c_NREG)
//           W_stall_o                    freeze W (comb)
//           stat_o, halt_o               architectural status, sticky halt
//           retire_valid_o, retire_pc_o  retire trace (registered)
//           instret_o, cycle_o           free-running wrap-around counters
// Rev     : 1.0  initial release
// ============================================================================
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int NUM_REGS = 15,
    parameter int CNT_W    = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [c_STAT_W-1:0]  W_stat_i,
    input  logic [c_ADDR_W-1:0]  W_pc_i,
    input  logic [c_ICODE_W-1:0] W_icode_i,
    input  logic [c_DATA_W-1:0]  W_valE_i,
    input  logic [c_DATA_W-1:0]  W_valM_i,
    input  logic [c_REG_W-1:0]   W_dstE_i,
    input  logic [c_REG_W-1:0]   W_dstM_i,
    input  logic [c_REG_W-1:0]   d_srcA_i,
    input  logic [c_REG_W-1:0]   d_srcB_i,
    output logic [c_DATA_W-1:0]  d_rvalA_o,
    output logic [c_DATA_W-1:0]  d_rvalB_o,
    output logic                 W_stall_o,
    output logic [c_STAT_W-1:0]  stat_o,
    output logic                 halt_o,
    output logic                 retire_valid_o,
    output logic [c_ADDR_W-1:0]  retire_pc_o,
    output logic [CNT_W-1:0]     instret_o,
    output logic [CNT_W-1:0]     cycle_o
);

    logic                r_halt;
    logic [c_STAT_W-1:0] r_stat;
    logic                r_retire_valid;
    logic [c_ADDR_W-1:0] r_retire_pc;
    logic [CNT_W-1:0]    r_instret;
    logic [CNT_W-1:0]    r_cycle;

    logic w_terminal;
    logic w_commit;
    logic w_retire;

    // icode does not affect writeback: a nop with AOK status retires like
    // any other instruction. Kept on the port for trace/debug hookup.
    logic w_unused_icode;
    assign w_unused_icode = ^W_icode_i;

    assign w_terminal = is_terminal(W_stat_i);
    assign w_commit   = !r_halt && (W_stat_i == c_SAOK);
    // A halt instruction itself retires; faults and bubbles do not.
    assign w_retire   = !r_halt && ((W_stat_i == c_SAOK) || (W_stat_i == c_SHLT));

    writeback_stage_regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (c_DATA_W)
    ) u_regfile (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_we    (w_commit),
        .i_dstE  (W_dstE_i),
        .i_valE  (W_valE_i),
        .i_dstM  (W_dstM_i),
        .i_valM  (W_valM_i),
        .i_srcA  (d_srcA_i),
        .i_srcB  (d_srcB_i),
        .o_rvalA (d_rvalA_o),
        .o_rvalB (d_rvalB_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_halt         <= 1'b0;
            r_stat         <= c_SAOK;
            r_retire_valid <= 1'b0;
            r_retire_pc    <= '0;
            r_instret      <= '0;
            r_cycle        <= '0;
        end else begin
            // Once halted, everything freezes until reset.
            if (!r_halt) begin
                r_cycle <= r_cycle + CNT_W'(1);
                if (w_terminal) begin
                    r_halt <= 1'b1;
                    r_stat <= W_stat_i;
                end
            end
            r_retire_valid <= w_retire;
            if (w_retire) begin
                r_retire_pc <= W_pc_i;
                r_instret   <= r_instret + CNT_W'(1);
            end
        end
    end

    // Stall as soon as a terminating instruction sits in W, before halt latches.
    assign W_stall_o      = r_halt | w_terminal;
    assign stat_o         = r_stat;
    assign halt_o         = r_halt;
    assign retire_valid_o = r_retire_valid;
    assign retire_pc_o    = r_retire_pc;
    assign instret_o      = r_instret;
    assign cycle_o        = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_writeback_stage
// Purpose : Directed, table-driven bench for writeback_stage plus hand
//           sequences for halt, reset and counter wrap (small-counter copy).
// Rev     : 1.0  initial release
// ============================================================================
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst2;
    logic [2:0]  W_stat;
    logic [2:0]  W_stat2;
    logic [63:0] W_pc;
    logic [3:0]  W_icode;
    logic [63:0] W_valE;
    logic [63:0] W_valM;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;

    logic [63:0] d_rvalA, d_rvalB;
    logic        W_stall, halt, retire_valid;
    logic [2:0]  stat;
    logic [63:0] retire_pc, instret, cycle;

    logic [63:0] d_rvalA2, d_rvalB2;
    logic        W_stall2, halt2, retire_valid2;
    logic [2:0]  stat2;
    logic [63:0] retire_pc2;
    logic [3:0]  instret2, cycle2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    writeback_stage #(.NUM_REGS(15), .CNT_W(64)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .W_stat_i(W_stat), .W_pc_i(W_pc), .W_icode_i(W_icode),
        .W_valE_i(W_valE), .W_valM_i(W_valM),
        .W_dstE_i(W_dstE), .W_dstM_i(W_dstM),
        .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .d_rvalA_o(d_rvalA), .d_rvalB_o(d_rvalB),
        .W_stall_o(W_stall), .stat_o(stat), .halt_o(halt),
        .retire_valid_o(retire_valid), .retire_pc_o(retire_pc),
        .instret_o(instret), .cycle_o(cycle)
    );

    // Narrow-counter copy so wrap-around is reachable in a few cycles.
    writeback_stage #(.NUM_REGS(15), .CNT_W(4)) u_dut_w (
        .clk_i(clk), .rst_i(rst2),
        .W_stat_i(W_stat2), .W_pc_i(W_pc), .W_icode_i(W_icode),
        .W_valE_i(W_valE), .W_valM_i(W_valM),
        .W_dstE_i(W_dstE), .W_dstM_i(W_dstM),
        .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
        .d_rvalA_o(d_rvalA2), .d_rvalB_o(d_rvalB2),
        .W_stall_o(W_stall2), .stat_o(stat2), .halt_o(halt2),
        .retire_valid_o(retire_valid2), .retire_pc_o(retire_pc2),
        .instret_o(instret2), .cycle_o(cycle2)
    );

    typedef struct {
        logic [2:0]  st;
        logic [3:0]  icode;
        logic [63:0] pc;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        logic [3:0]  srcA;
        logic [3:0]  srcB;
        logic [63:0] expA;
        logic [63:0] expB;
        logic        exp_rv;
        logic [63:0] exp_rpc;
        logic [63:0] exp_instret;
        logic [63:0] exp_cycle;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_w(input logic [2:0] s, input logic [63:0] pc,
                           input logic [3:0] de, input logic [63:0] ve,
                           input logic [3:0] dm, input logic [63:0] vm);
        W_stat = s; W_pc = pc; W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " halt"},    {63'd0, halt},         64'd0);
        check({tag, " stat"},    {61'd0, stat},         64'd1);
        check({tag, " rv"},      {63'd0, retire_valid}, 64'd0);
        check({tag, " rpc"},     retire_pc,             64'd0);
        check({tag, " instret"}, instret,               64'd0);
        check({tag, " cycle"},   cycle,                 64'd0);
    endtask

    initial begin
        // stat icode pc valE valM dstE dstM srcA srcB expA expB rv rpc instret cycle
        vecs[0] = '{3'd1, 4'h3, 64'h10, 64'h5,    64'h0,   4'h0, 4'hF, 4'h0, 4'hF,
                    64'h5,    64'h0,   1'b1, 64'h10, 64'd1, 64'd1};
        vecs[1] = '{3'd1, 4'hB, 64'h18, 64'h8,    64'h100, 4'h4, 4'h4, 4'h4, 4'h0,
                    64'h100,  64'h5,   1'b1, 64'h18, 64'd2, 64'd2};
        vecs[2] = '{3'd0, 4'h1, 64'h20, 64'h99,   64'h0,   4'h2, 4'hF, 4'h2, 4'h4,
                    64'h0,    64'h100, 1'b0, 64'h18, 64'd2, 64'd3};
        vecs[3] = '{3'd1, 4'h5, 64'h28, 64'h55,   64'h77,  4'hF, 4'h2, 4'h2, 4'hF,
                    64'h77,   64'h0,   1'b1, 64'h28, 64'd3, 64'd4};
        vecs[4] = '{3'd1, 4'h1, 64'h30, 64'h0,    64'h0,   4'hF, 4'hF, 4'h0, 4'h2,
                    64'h5,    64'h77,  1'b1, 64'h30, 64'd4, 64'd5};
        vecs[5] = '{3'd1, 4'h6, 64'h38, 64'hDEAD, 64'h0,   4'hE, 4'hF, 4'hE, 4'h4,
                    64'hDEAD, 64'h100, 1'b1, 64'h38, 64'd5, 64'd6};

        rst = 1'b1; rst2 = 1'b1; W_stat2 = 3'd1; W_icode = 4'h1;
        drive_w(3'd1, 64'h0, 4'h0, 64'hFFFF, 4'hF, 64'h0);
        d_srcA = 4'h0; d_srcB = 4'hF;
        step();
        check_reset_state("reset");
        check("reset regA", d_rvalA, 64'h0);
        rst = 1'b0;

        // Table: commits, popq priority, bubble, M-only, nop, r14
        for (int i = 0; i < 6; i++) begin
            drive_w(vecs[i].st, vecs[i].pc, vecs[i].dstE, vecs[i].valE,
                    vecs[i].dstM, vecs[i].valM);
            W_icode = vecs[i].icode;
            d_srcA = vecs[i].srcA; d_srcB = vecs[i].srcB;
            step();
            check($sformatf("v%0d rvalA", i), d_rvalA, vecs[i].expA);
            check($sformatf("v%0d rvalB", i), d_rvalB, vecs[i].expB);
            check($sformatf("v%0d rv", i), {63'd0, retire_valid}, {63'd0, vecs[i].exp_rv});
            check($sformatf("v%0d rpc", i), retire_pc, vecs[i].exp_rpc);
            check($sformatf("v%0d instret", i), instret, vecs[i].exp_instret);
            check($sformatf("v%0d cycle", i), cycle, vecs[i].exp_cycle);
            check($sformatf("v%0d stall", i), {63'd0, W_stall}, 64'd0);
            check($sformatf("v%0d halt", i), {63'd0, halt}, 64'd0);
        end

        // Address fault: stall immediately, halt next edge, nothing written
        drive_w(3'd3, 64'h40, 4'hF, 64'h0, 4'h3, 64'h7);
        d_srcA = 4'h3;
        #1;
        check("sadr stall comb", {63'd0, W_stall}, 64'd1);
        check("sadr halt pre", {63'd0, halt}, 64'd0);
        step();
        check("sadr halt", {63'd0, halt}, 64'd1);
        check("sadr stat", {61'd0, stat}, 64'd3);
        check("sadr rv", {63'd0, retire_valid}, 64'd0);
        check("sadr rpc", retire_pc, 64'h38);
        check("sadr instret", instret, 64'd5);
        check("sadr cycle", cycle, 64'd7);
        check("sadr reg3", d_rvalA, 64'h0);
        for (int i = 0; i < 5; i++) begin
            drive_w(3'd1, 64'h48 + 64'(i), 4'h3, 64'h11, 4'hF, 64'h0);
            step();
        end
        check("halted reg3", d_rvalA, 64'h0);
        check("halted cycle", cycle, 64'd7);
        check("halted instret", instret, 64'd5);
        check("halted rv", {63'd0, retire_valid}, 64'd0);
        check("halted stall", {63'd0, W_stall}, 64'd1);
        check("halted stat", {61'd0, stat}, 64'd3);

        // Reset out of halt, with a commit pending on the same edge
        rst = 1'b1;
        d_srcA = 4'h0; d_srcB = 4'h4;
        step();
        rst = 1'b0;
        check_reset_state("rst1");
        check("rst1 reg0", d_rvalA, 64'h0);
        check("rst1 reg4", d_rvalB, 64'h0);
        d_srcA = 4'h3;
        #1;
        check("rst1 reg3", d_rvalA, 64'h0);
        check("rst1 stall", {63'd0, W_stall}, 64'd0);

        // Halt instruction retires
        drive_w(3'd1, 64'h38, 4'h1, 64'hAB, 4'hF, 64'h0);
        d_srcA = 4'h1;
        step();
        drive_w(3'd2, 64'h40, 4'h1, 64'hCD, 4'hF, 64'h0);
        W_icode = 4'h0;
        step();
        check("shlt halt", {63'd0, halt}, 64'd1);
        check("shlt stat", {61'd0, stat}, 64'd2);
        check("shlt rv", {63'd0, retire_valid}, 64'd1);
        check("shlt rpc", retire_pc, 64'h40);
        check("shlt instret", instret, 64'd2);
        check("shlt cycle", cycle, 64'd2);
        check("shlt reg1", d_rvalA, 64'hAB);
        drive_w(3'd1, 64'h48, 4'h1, 64'hEE, 4'hF, 64'h0);
        W_icode = 4'h1;
        step();
        check("post-hlt rv", {63'd0, retire_valid}, 64'd0);
        check("post-hlt rpc", retire_pc, 64'h40);
        check("post-hlt instret", instret, 64'd2);
        check("post-hlt reg1", d_rvalA, 64'hAB);

        // Reset during a commit drops the write
        rst = 1'b1;
        drive_w(3'd1, 64'h50, 4'h5, 64'h9, 4'hF, 64'h0);
        d_srcA = 4'h1; d_srcB = 4'h5;
        step();
        rst = 1'b0;
        drive_w(3'd0, 64'h0, 4'hF, 64'h0, 4'hF, 64'h0);
        check_reset_state("rst2");
        check("rst2 reg1", d_rvalA, 64'h0);
        check("rst2 reg5", d_rvalB, 64'h0);
        d_srcA = 4'hF;
        #1;
        check("nreg read", d_rvalA, 64'h0);

        // Counter wrap on the 4-bit copy
        rst2 = 1'b1;
        W_stat2 = 3'd1;
        step();
        rst2 = 1'b0;
        check("w reset cycle", {60'd0, cycle2}, 64'd0);
        for (int i = 0; i < 15; i++) step();
        check("w cycle max", {60'd0, cycle2}, 64'hF);
        check("w instret max", {60'd0, instret2}, 64'hF);
        step();
        check("w cycle wrap", {60'd0, cycle2}, 64'd0);
        check("w instret wrap", {60'd0, instret2}, 64'd0);
        check("w halt", {63'd0, halt2}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
